key_edit: RTL and testbench

- Consumes the one-cycle key pulses produced by the key debouncer/edge stage and turns them into an editable multi-digit BCD setting.
- Typical use: setting a clock, alarm or threshold from six push-buttons.
- Holds a committed value and a working copy. The working copy is edited digit by digit, then either committed or discarded.
- Outputs drive the display stage: value, working copy, digit select and blink.

---
 rtl/key_edit_pkg.sv | 31 +++
 rtl/key_edit_blink.sv | 36 +++
 rtl/key_edit.sv | 155 +++++++++++++++
 tb/tb_key_edit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_edit_pkg.sv
// Shared definitions for the key_edit block: key bit positions, FSM state
// encoding and wrapping single-digit BCD arithmetic.
package key_edit_pkg;

  localparam int K_MODE  = 0;
  localparam int K_LEFT  = 1;
  localparam int K_RIGHT = 2;
  localparam int K_UP    = 3;
  localparam int K_DOWN  = 4;
  localparam int K_CONF  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    EDIT = 1'b1
  } state_t;

  // Out-of-range nibbles (10..15) behave like 9, so they land back in 0..9.
  function automatic logic [3:0] bcd_inc(input logic [3:0] nibble);
    return (nibble >= 4'd9) ? 4'd0 : nibble + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] nibble);
    if (nibble == 4'd0)
      return 4'd9;
    else if (nibble > 4'd9)
      return 4'd8;
    else
      return nibble - 4'd1;
  endfunction

endpackage

// File: rtl/key_edit_blink.sv
// blink_gen: square wave with BLINK_DIV-cycle half-period while enabled.
// restart forces the phase back to "on" at the start of a half-period.
module blink_gen #(
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic blink
);

  localparam int unsigned CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      blink   <= 1'b0;
    end else if (restart) begin
      cnt_reg <= '0;
      blink   <= 1'b1;
    end else if (!enable) begin
      cnt_reg <= '0;
      blink   <= 1'b0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
      blink   <= ~blink;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/key_edit.sv
// key_edit: turns debounced key pulses into an editable, committable BCD value.
// Optional KEY_EDIT_TIMEOUT_EN cancels an edit after TIMEOUT key-free cycles.
module key_edit
  import key_edit_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned BLINK_DIV = 25000000,
  parameter int unsigned TIMEOUT   = 250000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          key_pulse,
  output logic [4*DIGITS-1:0] value,
  output logic [4*DIGITS-1:0] work,
  output logic [DIGITS-1:0]   sel,
  output logic                editing,
  output logic                blink,
  output logic                done
);

  localparam int unsigned W = 4 * DIGITS;

  state_t            state_reg, state_next;
  logic [W-1:0]      value_reg, value_next;
  logic [W-1:0]      work_reg, work_next;
  logic [DIGITS-1:0] sel_reg, sel_next;
  logic              done_reg, done_next;
  logic              restart;
  logic              timeout_hit;

  logic [W-1:0]      work_inc, work_dec;
  logic [DIGITS-1:0] sel_left, sel_right;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign work_inc[4*gi +: 4] = sel_reg[gi] ? bcd_inc(work_reg[4*gi +: 4]) : work_reg[4*gi +: 4];
      assign work_dec[4*gi +: 4] = sel_reg[gi] ? bcd_dec(work_reg[4*gi +: 4]) : work_reg[4*gi +: 4];
    end

    if (DIGITS > 1) begin : g_rot
      assign sel_left  = {sel_reg[DIGITS-2:0], sel_reg[DIGITS-1]};
      assign sel_right = {sel_reg[0], sel_reg[DIGITS-1:1]};
    end else begin : g_no_rot
      assign sel_left  = sel_reg;
      assign sel_right = sel_reg;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    value_next = value_reg;
    work_next  = work_reg;
    sel_next   = sel_reg;
    done_next  = 1'b0;
    restart    = 1'b0;
    case (state_reg)
      IDLE: begin
        work_next = value_reg;
        if (key_pulse[K_MODE]) begin
          state_next = EDIT;
          sel_next   = DIGITS'(1);
          restart    = 1'b1;
        end
      end
      EDIT: begin
        // Single action per cycle, highest-priority key wins.
        if (key_pulse[K_MODE]) begin
          state_next = IDLE;
          work_next  = value_reg;
          sel_next   = '0;
        end else if (key_pulse[K_CONF]) begin
          state_next = IDLE;
          value_next = work_reg;
          done_next  = 1'b1;
          sel_next   = '0;
        end else if (key_pulse[K_UP]) begin
          work_next = work_inc;
          restart   = 1'b1;
        end else if (key_pulse[K_DOWN]) begin
          work_next = work_dec;
          restart   = 1'b1;
        end else if (key_pulse[K_LEFT]) begin
          sel_next = sel_left;
          restart  = 1'b1;
        end else if (key_pulse[K_RIGHT]) begin
          sel_next = sel_right;
          restart  = 1'b1;
        end else if (timeout_hit) begin
          state_next = IDLE;
          work_next  = value_reg;
          sel_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        sel_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      value_reg <= '0;
      work_reg  <= '0;
      sel_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      value_reg <= value_next;
      work_reg  <= work_next;
      sel_reg   <= sel_next;
      done_reg  <= done_next;
    end
  end

`ifdef KEY_EDIT_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] idle_cnt_reg;

  assign timeout_hit = (state_reg == EDIT) && (idle_cnt_reg == TW'(TIMEOUT - 1));

  // Any honoured key, entry into EDIT or leaving EDIT rearms the inactivity count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      idle_cnt_reg <= '0;
    else if (state_next != EDIT || restart)
      idle_cnt_reg <= '0;
    else
      idle_cnt_reg <= idle_cnt_reg + TW'(1);
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  blink_gen #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink (
    .clk    (clk),
    .rst    (rst),
    .enable (state_next == EDIT),
    .restart(restart),
    .blink  (blink)
  );

  assign value   = value_reg;
  assign work    = work_reg;
  assign sel     = sel_reg;
  assign editing = (state_reg == EDIT);
  assign done    = done_reg;

endmodule

// File: tb/tb_key_edit.sv
// Self-checking bench for key_edit (DIGITS=4, BLINK_DIV=4, TIMEOUT=16) with a
// digit-array reference model; honours KEY_EDIT_TIMEOUT_EN when defined.
module tb_key_edit;

  localparam int DIGITS    = 4;
  localparam int BLINK_DIV = 4;
  localparam int TIMEOUT   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  key_pulse;
  logic [15:0] value;
  logic [15:0] work;
  logic [3:0]  sel;
  logic        editing;
  logic        blink;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: one integer per decimal digit.
  int m_val[DIGITS];
  int m_work[DIGITS];
  int m_sel;
  bit m_edit;
  bit m_done;
  int m_since;
  int m_quiet;

  always #5 clk = ~clk;

  key_edit #(
    .DIGITS   (DIGITS),
    .BLINK_DIV(BLINK_DIV),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_pulse(key_pulse),
    .value    (value),
    .work     (work),
    .sel      (sel),
    .editing  (editing),
    .blink    (blink),
    .done     (done)
  );

  function automatic logic [15:0] exp_value();
    logic [15:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = m_val[i][3:0];
    return r;
  endfunction

  function automatic logic [15:0] exp_work();
    logic [15:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = m_work[i][3:0];
    return r;
  endfunction

  function automatic logic [3:0] exp_sel();
    return m_edit ? 4'(1 << m_sel) : 4'b0000;
  endfunction

  function automatic logic exp_blink();
    return m_edit && (((m_since / BLINK_DIV) % 2) == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DIGITS; i++) begin
      m_val[i]  = 0;
      m_work[i] = 0;
    end
    m_sel = 0; m_edit = 0; m_done = 0; m_since = 0; m_quiet = 0;
  endtask

  task automatic model_cancel();
    for (int i = 0; i < DIGITS; i++) m_work[i] = m_val[i];
    m_edit = 0;
  endtask

  task automatic model_step(input logic [5:0] k);
    m_done = 0;
    if (!m_edit) begin
      if (k[0]) begin
        for (int i = 0; i < DIGITS; i++) m_work[i] = m_val[i];
        m_edit = 1; m_sel = 0; m_since = 0; m_quiet = 0;
      end
    end else if (k[0]) begin
      model_cancel();
    end else if (k[5]) begin
      for (int i = 0; i < DIGITS; i++) m_val[i] = m_work[i];
      m_done = 1; m_edit = 0;
    end else if (k[3]) begin
      m_work[m_sel] = (m_work[m_sel] + 1) % 10; m_since = 0; m_quiet = 0;
    end else if (k[4]) begin
      m_work[m_sel] = (m_work[m_sel] + 9) % 10; m_since = 0; m_quiet = 0;
    end else if (k[1]) begin
      m_sel = (m_sel + 1) % DIGITS; m_since = 0; m_quiet = 0;
    end else if (k[2]) begin
      m_sel = (m_sel + DIGITS - 1) % DIGITS; m_since = 0; m_quiet = 0;
    end else begin
      m_since++;
`ifdef KEY_EDIT_TIMEOUT_EN
      m_quiet++;
      if (m_quiet == TIMEOUT) model_cancel();
`endif
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic [5:0] k);
    key_pulse = k;
    @(posedge clk);
    model_step(k);
    @(negedge clk);
    key_pulse = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_pulse = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (20) cycle(6'b000000);
    n_cmp++; if (value !== 16'h0000) begin n_bad++; $display("FAIL reset_value got=%h want=0000", value); end
    n_cmp++; if (sel !== 4'b0000) begin n_bad++; $display("FAIL reset_sel got=%b want=0000", sel); end
    n_cmp++; if (editing !== 1'b0) begin n_bad++; $display("FAIL reset_editing got=%b want=0", editing); end
    n_cmp++; if (blink !== 1'b0) begin n_bad++; $display("FAIL reset_blink got=%b want=0", blink); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
    cycle(6'b001000);
    n_cmp++; if (work !== 16'h0000) begin n_bad++; $display("FAIL idle_up_work got=%h want=0000", work); end
    n_cmp++; if (editing !== 1'b0) begin n_bad++; $display("FAIL idle_up_editing got=%b want=0", editing); end
  endtask

  task automatic test_commit();
    cycle(6'b000001);
    n_cmp++; if (sel !== 4'b0001 || editing !== 1'b1 || blink !== 1'b1) begin
      n_bad++; $display("FAIL enter_edit got sel=%b ed=%b bl=%b want 0001/1/1", sel, editing, blink);
    end
    repeat (3) cycle(6'b001000);
    cycle(6'b000010);
    cycle(6'b001000);
    n_cmp++; if (work !== 16'h0013 || sel !== 4'b0010) begin
      n_bad++; $display("FAIL edit_work got=%h sel=%b want 0013/0010", work, sel);
    end
    cycle(6'b100000);
    n_cmp++; if (value !== 16'h0013) begin n_bad++; $display("FAIL commit_value got=%h want=0013", value); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL commit_done got=%b want=1", done); end
    n_cmp++; if (editing !== 1'b0 || sel !== 4'b0000) begin
      n_bad++; $display("FAIL commit_exit got ed=%b sel=%b want 0/0000", editing, sel);
    end
    cycle(6'b000000);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_width got=%b want=0", done); end
  endtask

  task automatic test_wrap();
    cycle(6'b000001);
    cycle(6'b000010);
    cycle(6'b000010);
    n_cmp++; if (sel !== 4'b0100) begin n_bad++; $display("FAIL left_twice got=%b want=0100", sel); end
    cycle(6'b010000);
    n_cmp++; if (work !== 16'h0913) begin n_bad++; $display("FAIL down_wrap got=%h want=0913", work); end
    cycle(6'b001000);
    n_cmp++; if (work !== 16'h0013) begin n_bad++; $display("FAIL up_wrap got=%h want=0013", work); end
    cycle(6'b000100);
    cycle(6'b000100);
    n_cmp++; if (sel !== 4'b0001) begin n_bad++; $display("FAIL right_twice got=%b want=0001", sel); end
    cycle(6'b000100);
    n_cmp++; if (sel !== 4'b1000) begin n_bad++; $display("FAIL right_wrap got=%b want=1000", sel); end
    cycle(6'b000010);
    n_cmp++; if (sel !== 4'b0001) begin n_bad++; $display("FAIL left_wrap got=%b want=0001", sel); end
    cycle(6'b000001);
    n_cmp++; if (editing !== 1'b0 || work !== 16'h0013) begin
      n_bad++; $display("FAIL wrap_cancel got ed=%b work=%h want 0/0013", editing, work);
    end
  endtask

  task automatic test_cancel();
    bit seen_done = 0;
    cycle(6'b000001);
    repeat (5) begin
      cycle(6'b001000);
      if (done) seen_done = 1;
    end
    n_cmp++; if (work !== 16'h0018) begin n_bad++; $display("FAIL cancel_pre_work got=%h want=0018", work); end
    cycle(6'b000001);
    if (done) seen_done = 1;
    n_cmp++; if (value !== 16'h0013) begin n_bad++; $display("FAIL cancel_value got=%h want=0013", value); end
    n_cmp++; if (work !== 16'h0013) begin n_bad++; $display("FAIL cancel_work got=%h want=0013", work); end
    n_cmp++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL cancel_done got=%b want=0", seen_done); end
  endtask

  task automatic test_simultaneous();
    cycle(6'b000001);
    cycle(6'b001000);
    cycle(6'b101000);
    n_cmp++; if (value !== 16'h0014 || done !== 1'b1) begin
      n_bad++; $display("FAIL conf_up got value=%h done=%b want 0014/1", value, done);
    end
    cycle(6'b000001);
    cycle(6'b011000);
    n_cmp++; if (work !== 16'h0015) begin n_bad++; $display("FAIL up_down got=%h want=0015", work); end
    cycle(6'b000011);
    n_cmp++; if (editing !== 1'b0 || value !== 16'h0014 || work !== 16'h0014) begin
      n_bad++; $display("FAIL mode_left got ed=%b value=%h work=%h want 0/0014/0014", editing, value, work);
    end
  endtask

  task automatic test_blink_timeout();
    cycle(6'b000001);
    for (int n = 0; n <= 15; n++) begin
      n_cmp++; if (blink !== (((n / 4) % 2) == 0)) begin
        n_bad++; $display("FAIL blink_phase n=%0d got=%b want=%b", n, blink, ((n / 4) % 2) == 0);
      end
      n_cmp++; if (editing !== 1'b1) begin n_bad++; $display("FAIL blink_editing n=%0d got=%b want=1", n, editing); end
      cycle(6'b000000);
    end
`ifdef KEY_EDIT_TIMEOUT_EN
    n_cmp++; if (editing !== 1'b0 || blink !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL timeout_exit got ed=%b bl=%b done=%b want 0/0/0", editing, blink, done);
    end
    n_cmp++; if (value !== 16'h0014) begin n_bad++; $display("FAIL timeout_value got=%h want=0014", value); end
`else
    n_cmp++; if (editing !== 1'b1) begin n_bad++; $display("FAIL no_timeout got=%b want=1", editing); end
    cycle(6'b000001);
`endif
  endtask

  task automatic test_random();
    logic [5:0] k;
    int r;
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 9);
      if (r < 4) k = 6'b000000;
      else if (r < 8) k = 6'(1 << $urandom_range(1, 4));
      else if (r == 8) k = 6'($urandom_range(0, 63));
      else k = ($urandom_range(0, 1) != 0) ? 6'b000001 : 6'b100000;
      cycle(k);
      n_cmp++; if (value !== exp_value()) begin n_bad++; $display("FAIL rnd_value c=%0d key=%b got=%h want=%h", c, k, value, exp_value()); end
      n_cmp++; if (work !== exp_work()) begin n_bad++; $display("FAIL rnd_work c=%0d key=%b got=%h want=%h", c, k, work, exp_work()); end
      n_cmp++; if (sel !== exp_sel()) begin n_bad++; $display("FAIL rnd_sel c=%0d key=%b got=%b want=%b", c, k, sel, exp_sel()); end
      n_cmp++; if (editing !== m_edit) begin n_bad++; $display("FAIL rnd_editing c=%0d got=%b want=%b", c, editing, m_edit); end
      n_cmp++; if (blink !== exp_blink()) begin n_bad++; $display("FAIL rnd_blink c=%0d got=%b want=%b", c, blink, exp_blink()); end
      n_cmp++; if (done !== m_done) begin n_bad++; $display("FAIL rnd_done c=%0d got=%b want=%b", c, done, m_done); end
    end
  endtask

  task automatic test_async_reset();
    if (!m_edit) cycle(6'b000001);
    cycle(6'b001000);
    cycle(6'b000010);
    n_cmp++; if (editing !== 1'b1) begin n_bad++; $display("FAIL pre_reset_editing got=%b want=1", editing); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (value !== 16'h0 || work !== 16'h0 || sel !== 4'b0) begin
      n_bad++; $display("FAIL async_reset_data got value=%h work=%h sel=%b want 0/0/0", value, work, sel);
    end
    n_cmp++; if (editing !== 1'b0 || blink !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL async_reset_ctrl got ed=%b bl=%b done=%b want 0/0/0", editing, blink, done);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(6'b000000);
    n_cmp++; if (value !== 16'h0 || editing !== 1'b0) begin
      n_bad++; $display("FAIL post_reset got value=%h ed=%b want 0/0", value, editing);
    end
  endtask

  initial begin
    rst = 1'b1;
    key_pulse = '0;
    model_reset();
    test_reset();
    test_commit();
    test_wrap();
    test_cancel();
    test_simultaneous();
    test_blink_timeout();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
